// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Request/result bundle between the control FSM (master) and
//                the iterative multiply/divide engine (slave).
//                MULDIV_ABORT_EN adds the abort request line.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;
`ifdef MULDIV_ABORT_EN
  logic             abort;

  modport master (
    output start, op, a, b, abort,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b, abort,
    output hi, lo, busy, done, div_zero
  );
`else
  modport master (
    output start, op, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output hi, lo, busy, done, div_zero
  );
`endif
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative signed/unsigned multiply (radix-2 shift-add) and
//                divide (restoring) engine producing HI/LO, one bit per clock.
//                Optional macro MULDIV_ABORT_EN adds an abort request that
//                drops an operation in flight without committing a result.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               div_q,   div_d;    // latched op class: 1 = divide
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;    // product upper half
  logic [WIDTH-1:0]   shr_q,   shr_d;    // multiplier / dividend -> quotient
  logic [WIDTH-1:0]   opb_q,   opb_d;    // multiplicand / divisor magnitude
  logic [WIDTH:0]     rem_q,   rem_d;    // partial remainder
  logic               qsign_q, qsign_d;  // sign of product / quotient
  logic               rsign_q, rsign_d;  // sign of remainder
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;
  logic               dz_q,    dz_d;

  logic               abort_w;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     partial;
  logic [WIDTH+1:0]   shifted;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef MULDIV_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Operand magnitudes: only the signed ops (op[0] == 0) take absolute values.
  assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
  assign a_mag = a_neg ? -bus.a : bus.a;
  assign b_mag = b_neg ? -bus.b : bus.b;

  // Multiply step: add multiplicand into the upper half when the LSB is set.
  assign partial = shr_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};

  // Divide step: shift next dividend bit in and trial-subtract the divisor.
  // Two guard bits so a borrow shows up in trial[WIDTH+1].
  assign shifted = {rem_q, shr_q[WIDTH-1]};
  assign trial   = shifted - {2'b00, opb_q};

  assign prod_fix = qsign_q ? -{acc_q, shr_q} : {acc_q, shr_q};

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      shr_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shr_q   <= shr_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath update for IDLE -> RUN -> FIX -> DONE.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shr_d   = shr_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          div_d   = bus.op[1];
          cnt_d   = CNT_W'(WIDTH);
          acc_d   = '0;
          rem_d   = '0;
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          if (bus.op[1]) begin
            shr_d = a_mag;
            opb_d = b_mag;
          end else begin
            shr_d = b_mag;
            opb_d = a_mag;
          end
          // Divide by zero skips the iterations and leaves hi/lo untouched.
          if (bus.op[1] && (bus.b == '0)) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            dz_d    = 1'b0;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (div_q) begin
            rem_d = trial[WIDTH+1] ? shifted[WIDTH:0] : trial[WIDTH:0];
            shr_d = {shr_q[WIDTH-2:0], ~trial[WIDTH+1]};
          end else begin
            {acc_d, shr_d} = {partial, shr_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else begin
          if (div_q) begin
            lo_d = qsign_q ? -shr_q : shr_q;
            hi_d = rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.done     = (state_q == S_DONE);
  assign bus.div_zero = (state_q == S_DONE) && dz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
//                Abort sequence is included when MULDIV_ABORT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8  ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(bus8));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          w8;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit w8, input logic st, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      bus8.start = st; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
    end else begin
      bus32.start = st; bus32.op = op; bus32.a = a; bus32.b = b;
    end
  endtask

  task automatic peek(input bit w8, output logic dn, output logic bz, output logic dz,
                      output logic [31:0] hi, output logic [31:0] lo);
    if (w8) begin
      dn = bus8.done; bz = bus8.busy; dz = bus8.div_zero;
      hi = {24'h0, bus8.hi}; lo = {24'h0, bus8.lo};
    end else begin
      dn = bus32.done; bz = bus32.busy; dz = bus32.div_zero;
      hi = bus32.hi; lo = bus32.lo;
    end
  endtask

  // One-cycle start pulse; returns #1 after E0, i.e. in cycle 1 of the op.
  task automatic issue(input bit w8, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    drive(w8, 1'b1, op, a, b);
    @(posedge clock); #1;
    drive(w8, 1'b0, op, a, b);
  endtask

  // Waits (bounded) for done, pops the scoreboard and compares.
  // rp >= 1 re-pulses start (as a divide by zero) in that cycle of the op.
  task automatic wait_done(input bit w8, input string tag, input int rp);
    int lat = 1;
    int bcnt = 0;
    logic dn, bz, dz;
    logic [31:0] hi, lo;
    exp_t e;
    peek(w8, dn, bz, dz, hi, lo);
    while (!dn && lat < 200) begin
      if (bz) bcnt++;
      if (lat == rp)     drive(w8, 1'b1, 2'b11, 32'h1234, 32'h0);
      if (lat == rp + 1) drive(w8, 1'b0, 2'b11, 32'h1234, 32'h0);
      @(posedge clock); #1;
      lat++;
      peek(w8, dn, bz, dz, hi, lo);
    end
    e = sb.pop_front();
    check({tag, " done"},     64'(dn),   64'd1);
    check({tag, " latency"},  64'(lat),  64'(e.lat));
    check({tag, " busy cyc"}, 64'(bcnt), 64'(e.busy));
    check({tag, " busy@done"}, 64'(bz),  64'd0);
    check({tag, " hi"},       64'(hi),   64'(e.hi));
    check({tag, " lo"},       64'(lo),   64'(e.lo));
    check({tag, " div_zero"}, 64'(dz),   64'(e.dz));
    @(posedge clock); #1;
    peek(w8, dn, bz, dz, hi, lo);
    check({tag, " done pulse"}, 64'(dn), 64'd0);
  endtask

  task automatic quiet(input bit w8, input int n, input string tag);
    int seen = 0;
    logic dn, bz, dz;
    logic [31:0] hi, lo;
    repeat (n) begin
      @(posedge clock); #1;
      peek(w8, dn, bz, dz, hi, lo);
      if (dn) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic dn, bz, dz;
    logic [31:0] hi, lo;
    int w;

    //            w8  op     a             b             hi            lo            dz
    vecs[0]  = '{0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[1]  = '{0, 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{0, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{0, 2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    vecs[5]  = '{0, 2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[6]  = '{0, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7]  = '{0, 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{0, 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
    vecs[9]  = '{0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[10] = '{0, 2'b10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b1};
    vecs[11] = '{0, 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[12] = '{0, 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
    vecs[13] = '{0, 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0};
    vecs[14] = '{1, 2'b11, 32'h0000_00C8, 32'h0000_0007, 32'h0000_0004, 32'h0000_001C, 1'b0};
    vecs[15] = '{1, 2'b00, 32'h0000_00FD, 32'h0000_0007, 32'h0000_00FF, 32'h0000_00EB, 1'b0};
    vecs[16] = '{1, 2'b10, 32'h0000_0080, 32'h0000_00FF, 32'h0000_0000, 32'h0000_0080, 1'b0};
    vecs[17] = '{1, 2'b01, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FE, 32'h0000_0001, 1'b0};

    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
`ifdef MULDIV_ABORT_EN
    bus32.abort = 1'b0;
    bus8.abort  = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    peek(1'b0, dn, bz, dz, hi, lo);
    check("rst32 hi", 64'(hi), 64'd0);
    check("rst32 lo", 64'(lo), 64'd0);
    check("rst32 busy/done/dz", 64'({bz, dn, dz}), 64'd0);
    peek(1'b1, dn, bz, dz, hi, lo);
    check("rst8 hi/lo", 64'({hi, lo}), 64'd0);
    check("rst8 busy/done/dz", 64'({bz, dn, dz}), 64'd0);

    // Table-driven operations
    for (int i = 0; i < 18; i++) begin
      w = vecs[i].w8 ? 8 : 32;
      sb.push_back('{hi: vecs[i].hi, lo: vecs[i].lo, dz: vecs[i].dz,
                     lat: vecs[i].dz ? 1 : w + 2, busy: vecs[i].dz ? 0 : w + 1});
      issue(vecs[i].w8, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].w8, $sformatf("vec%0d", i), -1);
    end

    // start re-pulsed during RUN must be ignored
    sb.push_back('{hi: 32'h0, lo: 32'hF, dz: 1'b0, lat: 34, busy: 33});
    issue(1'b0, 2'b01, 32'h3, 32'h5);
    wait_done(1'b0, "repulse", 4);
    quiet(1'b0, 40, "repulse no 2nd done");

`ifdef MULDIV_ABORT_EN
    // abort in RUN: busy drops after one edge, no done, hi/lo kept
    issue(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (2) @(posedge clock);
    #1 bus32.abort = 1'b1;
    @(posedge clock); #1;
    bus32.abort = 1'b0;
    peek(1'b0, dn, bz, dz, hi, lo);
    check("abort busy", 64'(bz), 64'd0);
    quiet(1'b0, 40, "abort no done");
    peek(1'b0, dn, bz, dz, hi, lo);
    check("abort hi", 64'(hi), 64'h0);
    check("abort lo", 64'(lo), 64'hF);
    check("abort div_zero", 64'(dz), 64'd0);
`endif

    // Asynchronous reset in RUN clears outputs at once; no done follows
    issue(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    peek(1'b0, dn, bz, dz, hi, lo);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    check("midrst busy/done/dz", 64'({bz, dn, dz}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    quiet(1'b0, 40, "midrst no done");
    peek(1'b0, dn, bz, dz, hi, lo);
    check("midrst idle", 64'({hi, lo, bz}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
